// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared types and helpers for the AXI4-lite memory responder.
// Holds response codes, the read/write FSM state encodings and the
// byte-address to word-index conversion used by both channels.
package AxiLiteSlvPkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_WAITW,
    WR_WAITA,
    WR_WRITE,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_MEM,
    RD_RESP
  } rd_state_t;

  // Full-width word index relative to the base; the caller slices it to the
  // RAM depth and uses the upper bits for range checking. addr[2:0] drop out.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-lite bus bundle between a master and the memory responder.
// Ports: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//        B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
interface axi_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave_sram.sv
// Single-port synchronous RAM with per-byte write enables.
// Latency: read data appears on o_rdat one cycle after i_en && !i_we.
// Ports: clk, rstn, i_en, i_we, i_be, i_addr, i_wdat, o_rdat (holds between reads).
module axi_lite_sram #(
  parameter int DEPTH = 4096,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdat,
  output logic [DW-1:0]   o_rdat
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
      end
    end
  end

  // Output register only reloads on a read, so it stays stable while the
  // responder holds a read response, even if writes land meanwhile.
  always_ff @(posedge clk) begin
    if (!rstn)              r_q <= '0;
    else if (i_en && !i_we) r_q <= r_mem[i_addr];
  end

  assign o_rdat = r_q;
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-lite responder over a byte-writable single-port RAM; independent read/write FSMs.
// Latency: AW+W -> bvalid 2 cycles; AR -> rvalid 2 cycles (+1 per write conflict on the port).
// Backpressure: one transaction per channel in flight; readies low until B/R accepted.
// Ports: clk, rstn (sync, active-low), s_axi (slave modport of axi_lite_mem_slave_if).
// Option: define AXI_SLAVE_ERR_EN to return SLVERR for out-of-window accesses.
module axi_lite_mem_slave
  import AxiLiteSlvPkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          MEM_DEPTH  = 4096,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input logic                 clk,
  input logic                 rstn,
  axi_lite_mem_slave_if.slave s_axi
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
`ifdef AXI_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  wr_state_t               r_wr_state;
  rd_state_t               r_rd_state;
  logic                    r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rd_err;
  logic [1:0]              r_bresp, r_rresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;

  logic        w_aw_hs, w_w_hs, w_ar_hs;
  logic [63:0] w_wr_idx, w_rd_idx;
  logic        w_wr_err, w_rd_err, w_wr_port, w_ram_we, w_rd_issue;
  logic [IDX_W-1:0]      w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_aw_hs = s_axi.awvalid && r_awready;
  assign w_w_hs  = s_axi.wvalid && r_wready;
  assign w_ar_hs = s_axi.arvalid && r_arready;

  assign w_wr_idx = word_index(64'(r_awaddr), BASE_ADDR);
  assign w_rd_idx = word_index(64'(r_araddr), BASE_ADDR);
  assign w_wr_err = ERR_EN && ((64'(r_awaddr) < BASE_ADDR) || (w_wr_idx >= 64'(MEM_DEPTH)));
  assign w_rd_err = ERR_EN && ((64'(r_araddr) < BASE_ADDR) || (w_rd_idx >= 64'(MEM_DEPTH)));

  // The write FSM owns the port for its whole WR_WRITE cycle, even when an
  // erroring write is suppressed, so read latency does not depend on errors.
  assign w_wr_port  = (r_wr_state == WR_WRITE);
  assign w_ram_we   = w_wr_port && !w_wr_err;
  assign w_rd_issue = (r_rd_state == RD_MEM) && !w_wr_port;
  assign w_ram_addr = w_wr_port ? w_wr_idx[IDX_W-1:0] : w_rd_idx[IDX_W-1:0];

  axi_lite_sram #(.DEPTH(MEM_DEPTH), .DW(DATA_WIDTH), .AW(IDX_W)) u_sram (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_ram_we || w_rd_issue),
    .i_we   (w_ram_we),
    .i_be   (r_wstrb),
    .i_addr (w_ram_addr),
    .i_wdat (r_wdata),
    .o_rdat (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_wr_state <= WR_WRITE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
          end else if (w_aw_hs) begin
            r_wr_state <= WR_WAITW;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
          end else if (w_w_hs) begin
            r_wr_state <= WR_WAITA;
            r_awready  <= 1'b1;
            r_wready   <= 1'b0;
          end else begin
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        WR_WAITW: if (w_w_hs) begin
          r_wr_state <= WR_WRITE;
          r_wready   <= 1'b0;
        end
        WR_WAITA: if (w_aw_hs) begin
          r_wr_state <= WR_WRITE;
          r_awready  <= 1'b0;
        end
        WR_WRITE: begin
          r_wr_state <= WR_RESP;
          r_bvalid   <= 1'b1;
          r_bresp    <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
        end
        WR_RESP: if (s_axi.bready) begin
          r_wr_state <= WR_IDLE;
          r_bvalid   <= 1'b0;
          r_awready  <= 1'b1;
          r_wready   <= 1'b1;
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rd_err   <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          r_arready <= !w_ar_hs;
          if (w_ar_hs) begin
            r_araddr   <= s_axi.araddr;
            r_rd_state <= RD_MEM;
          end
        end
        RD_MEM: if (w_rd_issue) begin
          r_rd_state <= RD_RESP;
          r_rvalid   <= 1'b1;
          r_rd_err   <= w_rd_err;
          r_rresp    <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        end
        RD_RESP: if (s_axi.rready) begin
          r_rd_state <= RD_IDLE;
          r_rvalid   <= 1'b0;
          r_arready  <= 1'b1;
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  // RAM output register holds the word read in RD_MEM; errored reads are zeroed.
  assign s_axi.rdata   = w_ram_q & {DATA_WIDTH{~r_rd_err}};
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
module tb_axi_lite_mem_slave;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  axi_lite_mem_slave_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  axi_lite_mem_slave #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_axi (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // Drives AW and W together; lat counts cycles from the last handshake to bvalid.
  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output int lat, output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      tick(); n++;
      if (aw_now) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin bus.wvalid = 1'b0;  w_done = 1;  end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 1;
    while (!bus.bvalid && lat < 20) begin tick(); lat++; end
    resp = bus.bresp;
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [63:0] d,
                          output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin tick(); n++; end
    tick();
    bus.arvalid = 1'b0;
    lat = 1;
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (3) tick();
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b want 0", bus.awready); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", bus.wready); end
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", bus.arready); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bus.bvalid); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b want 00", bus.bresp); end
    checks++; if (bus.rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b want 00", bus.rresp); end
    checks++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    rstn = 1'b1;
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_rel_early: got %b want 0", bus.awready); end
    tick();
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL rst_readies_up: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
  endtask

  task automatic test_write_read();
    int lat; logic [1:0] resp; logic [63:0] d;
    axi_write(BASE + 64'd8, 64'h1122334455667788, 8'hFF, lat, resp);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d want 2", lat); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b want 00", resp); end
    axi_read(BASE + 64'd8, d, resp, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d want 2", lat); end
    checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data: got %h want 1122334455667788", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got %b want 00", resp); end
    // Unaligned byte address within the same word returns the full word.
    axi_read(BASE + 64'd13, d, resp, lat);
    checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL rd_unaligned: got %h want 1122334455667788", d); end
  endtask

  task automatic test_w_before_aw();
    int lat; logic [1:0] resp; logic [63:0] d;
    axi_write(BASE, 64'h0, 8'hFF, lat, resp);
    bus.wdata = 64'hAAAAAAAA_BBBBBBBB; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wdata = '0;
    checks++; if ({bus.awready, bus.wready} !== 2'b10) begin
      errors++; $display("FAIL waita_readies: got %b want 10", {bus.awready, bus.wready}); end
    tick();
    bus.awaddr = BASE; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    lat = 1;
    while (!bus.bvalid && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL waita_lat: got %0d want 2", lat); end
    checks++; if (bus.bresp !== 2'b00) begin errors++; $display("FAIL waita_bresp: got %b want 00", bus.bresp); end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    axi_read(BASE, d, resp, lat);
    checks++; if (d !== 64'h00000000_BBBBBBBB) begin errors++; $display("FAIL strb_data: got %h want 00000000bbbbbbbb", d); end
  endtask

  task automatic test_conflict();
    int lat, bl, rl; logic [1:0] resp;
    axi_write(BASE + 64'd16, 64'h5555555555555555, 8'hFF, lat, resp);
    bus.awaddr = BASE + 64'd16; bus.wdata = 64'h0123456789ABCDEF; bus.wstrb = 8'hFF;
    bus.araddr = BASE + 64'd16;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bl = 0; rl = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.bvalid && bl == 0) bl = c;
      if (bus.rvalid && rl == 0) rl = c;
      tick();
    end
    checks++; if (bl !== 2) begin errors++; $display("FAIL conf_blat: got %0d want 2", bl); end
    checks++; if (rl !== 3) begin errors++; $display("FAIL conf_rlat: got %0d want 3", rl); end
    checks++; if (bus.rdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL conf_rdata: got %h want 0123456789abcdef", bus.rdata); end
    bus.bready = 1'b1; bus.rready = 1'b1; tick(); bus.bready = 1'b0; bus.rready = 1'b0;
    checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
      errors++; $display("FAIL conf_release: got %b want 00", {bus.bvalid, bus.rvalid}); end
  endtask

  task automatic test_backpressure();
    int n;
    bus.awaddr = BASE + 64'd24; bus.wdata = 64'hDEADBEEF_CAFEF00D; bus.wstrb = 8'hFF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick(); tick();
    bus.awaddr = BASE + 64'd32; bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL bhold_bvalid%0d: got %b want 1", i, bus.bvalid); end
      checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL bhold_awready%0d: got %b want 0", i, bus.awready); end
      tick();
    end
    bus.awvalid = 1'b0; bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL bhold_drop: got %b want 0", bus.bvalid); end
    bus.araddr = BASE + 64'd24; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin tick(); n++; end
    bus.araddr = BASE; bus.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rhold_rvalid%0d: got %b want 1", i, bus.rvalid); end
      checks++; if (bus.rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rhold_rdata%0d: got %h want deadbeefcafef00d", i, bus.rdata); end
      checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rhold_arready%0d: got %b want 0", i, bus.arready); end
      tick();
    end
    bus.arvalid = 1'b0; bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    tick(); tick();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rhold_no_extra: got %b want 0", bus.rvalid); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [1:0] resp; logic [63:0] d;
    axi_write(BASE + 64'(DEPTH) * 64'd8, 64'hFEEDFACE_01234567, 8'hFF, lat, resp);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_wlat: got %0d want 2", lat); end
`ifdef AXI_SLAVE_ERR_EN
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b want 10", resp); end
    axi_read(BASE, d, resp, lat);
    checks++; if (d !== 64'h00000000_BBBBBBBB) begin errors++; $display("FAIL oor_word0: got %h want 00000000bbbbbbbb", d); end
    axi_read(BASE + 64'(DEPTH) * 64'd8, d, resp, lat);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", d); end
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_rresp: got %b want 10", resp); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_rlat: got %0d want 2", lat); end
    axi_read(BASE - 64'd8, d, resp, lat);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL below_base_rresp: got %b want 10", resp); end
`else
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL alias_bresp: got %b want 00", resp); end
    axi_read(BASE, d, resp, lat);
    checks++; if (d !== 64'hFEEDFACE_01234567) begin errors++; $display("FAIL alias_word0: got %h want feedface01234567", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL alias_rresp: got %b want 00", resp); end
    axi_read(BASE + 64'(DEPTH) * 64'd8 + 64'd8, d, resp, lat);
    checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL alias_word1: got %h want 1122334455667788", d); end
`endif
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [1:0] resp; logic [63:0] d;
    axi_write(BASE + 64'd40, 64'h0BADC0DE_0BADC0DE, 8'hFF, lat, resp);
    bus.awaddr = BASE + 64'd40; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    checks++; if ({bus.awready, bus.wready} !== 2'b01) begin
      errors++; $display("FAIL waitw_readies: got %b want 01", {bus.awready, bus.wready}); end
    bus.wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    rstn = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
      errors++; $display("FAIL midrst_valids: got %b want 00", {bus.bvalid, bus.rvalid}); end
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
      errors++; $display("FAIL midrst_readies: got %b want 000", {bus.awready, bus.wready, bus.arready}); end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL midrst_readies_up: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_b: got %b want 0", bus.bvalid); end
    axi_read(BASE + 64'd40, d, resp, lat);
    checks++; if (d !== 64'h0BADC0DE_0BADC0DE) begin errors++; $display("FAIL midrst_word: got %h want 0badc0de0badc0de", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_conflict();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-lite responder backed by a single-port, byte-writable synchronous RAM. It is the slave end of the core's if/mem/mmio AXI-lite master ports and serves as the instruction/data memory model for simulation and FPGA builds. Read and write channels have independent FSMs that share one RAM port; writes win on conflict.

## Interface
Parameters:
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width; only 64 is supported
- MEM_DEPTH, 4096, RAM depth in 64-bit words; power of two
- BASE_ADDR, 64'h0, byte address mapped to RAM word 0

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- awaddr  in  ADDR_WIDTH  write address; awvalid in 1; awready out 1
- wdata  in  DATA_WIDTH  write data; wstrb in DATA_WIDTH/8 byte strobes; wvalid in 1; wready out 1
- bresp  out  2  write response; bvalid out 1; bready in 1
- araddr  in  ADDR_WIDTH  read address; arvalid in 1; arready out 1
- rdata  out  DATA_WIDTH  read data; rresp out 2; rvalid out 1; rready in 1

## Operation
- Word index = (addr − BASE_ADDR) >> 3; addr[2:0] ignored; full 64-bit word always returned.
- Write FSM: WR_IDLE (awready=1, wready=1) → on AW only: WR_WAITW (awready=0); on W only: WR_WAITA (wready=0); on both: WR_WRITE. WR_WAITW/WR_WAITA → WR_WRITE when the missing beat handshakes. WR_WRITE: one cycle, RAM written with wstrb byte enables → WR_RESP. WR_RESP: bvalid=1, hold until bready → WR_IDLE.
- Read FSM: RD_IDLE (arready=1) → on AR handshake: RD_MEM. RD_MEM: issue RAM read; if write FSM is in WR_WRITE the same cycle, stay in RD_MEM (retry next cycle). Otherwise → RD_RESP. RD_RESP: rvalid=1, rdata/rresp stable until rready → RD_IDLE.
- Address and data latched on handshake; no dependence on master holding them.
- No outstanding-transaction pipelining: one read and one write in flight max.
- Read issued in the same cycle as a write to the same word returns old data only if it reaches RAM first; the write always wins the port.

## Timing
- Reset (rstn low at a clk edge): both FSMs to IDLE; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0. Readies are registered and rise the first cycle after rstn samples high. RAM contents not reset.
- Reset mid-transaction aborts it; a partially accepted write is not committed.
- Write latency, AW+W in cycle 0: RAM write cycle 1, bvalid cycle 2.
- Read latency, AR in cycle 0: RAM read cycle 1, rvalid cycle 2; +1 cycle per write conflict.
- Valid outputs never drop without the matching ready; readies are independent of the master's valids.

## Configuration
- AXI_SLAVE_ERR_EN defined: offset ≥ MEM_DEPTH*8 or addr < BASE_ADDR → write suppressed, bresp=2'b10; read returns rdata=0, rresp=2'b10. Latency unchanged.
- Undefined: index taken modulo MEM_DEPTH (wrap-around); responses always 2'b00.

## Structure
- Package AxiLiteSlvPkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_t and rd_state_t enums, word-index function.
- Sub-module axi_lite_sram: single-port sync RAM with we, per-byte enables, 1-cycle read latency.

## Test plan
- Write 64'h1122334455667788, wstrb 8'hFF to BASE_ADDR+8, then read same → bvalid cycle 2, rdata 64'h1122334455667788, rresp 0.
- W beat 2 cycles before AW with wstrb 8'h0F, data 64'hAAAAAAAA_BBBBBBBB over prior word 0 → bresp 0; read returns 64'h00000000_BBBBBBBB.
- Write in WR_WRITE same cycle as read in RD_MEM → read delayed one cycle, rvalid cycle 3.
- Hold bready/rready low 5 cycles → bvalid/rvalid and data stable; no new AW/AR accepted.
- Access BASE_ADDR+MEM_DEPTH*8 → with AXI_SLAVE_ERR_EN resp 2'b10 and word 0 unchanged; without, aliases word 0.
- Assert rstn low during WR_WAITW → all valids 0, target word unchanged, readies 1 cycle after release.
